// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the parking entry-barrier controller: gate state
// encoding, default parameter values and a small elaboration helper.
package parking_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED   = 2'd0,
    ST_RAISING  = 2'd1,
    ST_OPEN     = 2'd2,
    ST_LOWERING = 2'd3
  } gate_state_e;

  localparam int unsigned CAPACITY_DEF   = 32'd8;
  localparam int unsigned CNT_W_DEF      = 32'd4;
  localparam int unsigned TRAVEL_CYC_DEF = 32'd16;
  localparam int unsigned HOLD_CYC_DEF   = 32'd64;
  localparam int unsigned DEB_CYC_DEF    = 32'd4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_sensor_debounce.sv
// Car-sensor conditioner: 2-flop synchroniser, then a level that only follows
// the synced input after DEB_CYC consecutive identical samples.
module sensor_debounce
  import parking_gate_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned DW = (DEB_CYC > 32'd1) ? $clog2(DEB_CYC) : 32'd1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // cnt_q holds how many differing samples have already been seen
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DW'(DEB_CYC - 32'd1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry-barrier controller: gate FSM with a shared travel/hold timer and a
// saturating lot occupancy counter fed by debounced entry/exit sensors.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int unsigned CAPACITY   = CAPACITY_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TRAVEL_CYC = TRAVEL_CYC_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned DEB_CYC    = DEB_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             access_ok,
  input  logic             ent_sensor,
  input  logic             exit_sensor,
  output logic             motor_up,
  output logic             motor_down,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             hold_tmo
);

  localparam int unsigned TMR_MAX = max_u(TRAVEL_CYC, HOLD_CYC);
  localparam int unsigned TMR_W   = (TMR_MAX > 32'd1) ? $clog2(TMR_MAX) : 32'd1;

  gate_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             seen_car_q, seen_car_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             lot_full_q, lot_full_d;
  logic             hold_tmo_q, hold_tmo_d;
  logic             motor_up_q, motor_up_d;
  logic             motor_down_q, motor_down_d;
  logic             gate_open_q, gate_open_d;

  logic ent_lvl_s, ent_rise_s, ent_fall_s;
  logic exit_lvl_s, exit_rise_s, exit_fall_s;
  logic car_passed_s, tmo_s;
  logic unused_exit_s;

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_ent_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (ent_sensor),
    .level   (ent_lvl_s),
    .rise    (ent_rise_s),
    .fall    (ent_fall_s)
  );

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_exit_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (exit_sensor),
    .level   (exit_lvl_s),
    .rise    (exit_rise_s),
    .fall    (exit_fall_s)
  );

  assign unused_exit_s = exit_lvl_s ^ exit_fall_s;

  // Gate FSM; the timer restarts from zero on every state change
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    seen_car_d   = 1'b0;
    car_passed_s = 1'b0;
    tmo_s        = 1'b0;
    case (state_q)
      ST_CLOSED: begin
        timer_d = '0;
        if (access_ok && !lot_full_q) begin
          state_d = ST_RAISING;
        end else begin
          state_d = ST_CLOSED;
        end
      end
      ST_RAISING: begin
        if (timer_q == TMR_W'(TRAVEL_CYC - 32'd1)) begin
          state_d = ST_OPEN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OPEN: begin
        seen_car_d = seen_car_q | ent_rise_s;
        if (ent_fall_s && seen_car_q) begin
          car_passed_s = 1'b1;
          seen_car_d   = 1'b0;
          state_d      = ST_LOWERING;
          timer_d      = '0;
        end else if (ent_lvl_s) begin
          timer_d = timer_q;
        end else if (timer_q == TMR_W'(HOLD_CYC - 32'd1)) begin
          tmo_s      = 1'b1;
          seen_car_d = 1'b0;
          state_d    = ST_LOWERING;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LOWERING: begin
        // Something in the lane while closing: reverse and run a full raise
        if (ent_lvl_s) begin
          state_d = ST_RAISING;
          timer_d = '0;
        end else if (timer_q == TMR_W'(TRAVEL_CYC - 32'd1)) begin
          state_d = ST_CLOSED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_CLOSED;
        timer_d = '0;
      end
    endcase
  end

  // Occupancy update and registered output decode
  always_comb begin
    occ_d = occ_q;
    if (car_passed_s && !exit_rise_s) begin
      if (occ_q < CNT_W'(CAPACITY)) begin
        occ_d = occ_q + 1'b1;
      end else begin
        occ_d = occ_q;
      end
    end else if (exit_rise_s && !car_passed_s) begin
      if (occ_q != '0) begin
        occ_d = occ_q - 1'b1;
      end else begin
        occ_d = occ_q;
      end
    end else begin
      occ_d = occ_q;
    end
    lot_full_d   = (occ_d == CNT_W'(CAPACITY));
    hold_tmo_d   = tmo_s;
    motor_up_d   = (state_d == ST_RAISING);
    motor_down_d = (state_d == ST_LOWERING);
    gate_open_d  = (state_d == ST_OPEN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_CLOSED;
      timer_q      <= '0;
      seen_car_q   <= 1'b0;
      occ_q        <= '0;
      lot_full_q   <= 1'b0;
      hold_tmo_q   <= 1'b0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      gate_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      seen_car_q   <= seen_car_d;
      occ_q        <= occ_d;
      lot_full_q   <= lot_full_d;
      hold_tmo_q   <= hold_tmo_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      gate_open_q  <= gate_open_d;
    end
  end

  assign motor_up   = motor_up_q;
  assign motor_down = motor_down_q;
  assign gate_open  = gate_open_q;
  assign occupancy  = occ_q;
  assign lot_full   = lot_full_q;
  assign hold_tmo   = hold_tmo_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: stimulus pushes expected output
// changes (cycle + value); a negedge monitor pops on every observed change.
module tb_parking_gate_ctrl;

  localparam int CAP = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       access_ok;
  logic       ent_sensor;
  logic       exit_sensor;
  logic       motor_up;
  logic       motor_down;
  logic       gate_open;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       hold_tmo;

  parking_gate_ctrl #(
    .CAPACITY   (2),
    .CNT_W      (4),
    .TRAVEL_CYC (16),
    .HOLD_CYC   (64),
    .DEB_CYC    (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .access_ok   (access_ok),
    .ent_sensor  (ent_sensor),
    .exit_sensor (exit_sensor),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .gate_open   (gate_open),
    .occupancy   (occupancy),
    .lot_full    (lot_full),
    .hold_tmo    (hold_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  logic [8:0] prev_v = '0;
  logic [8:0] mon_v;
  ev_t        mon_e;
  int         occ_exp = 0;

  // Vector layout: {motor_up, motor_down, gate_open, lot_full, hold_tmo, occupancy}
  function automatic logic [8:0] mk(input bit mu, input bit md, input bit go,
                                    input bit ht, input int occ);
    logic [3:0] o;
    o = occ[3:0];
    return {mu, md, go, (occ == CAP), ht, o};
  endfunction

  function automatic logic [8:0] cur_v();
    return {motor_up, motor_down, gate_open, lot_full, hold_tmo, occupancy};
  endfunction

  task automatic push(input int c, input logic [8:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, want);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every change of the output vector must match the queue head
  always @(negedge clk) begin
    if (mon_en) begin
      mon_v = cur_v();
      if (mon_v !== prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h previous=%h", cyc, mon_v, prev_v);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_v !== mon_e.v || cyc != mon_e.cyc) begin
            failures++;
            $display("FAIL event cyc=%0d got=%h required cyc=%0d val=%h",
                     cyc, mon_v, mon_e.cyc, mon_e.v);
          end
        end
        prev_v = mon_v;
      end
    end
  end

  // Full entry cycle; with_exit puts an exit rise in the same cycle as the car-passed event
  task automatic car_entry(input string name, input bit with_exit);
    int c0;
    int occ_new;
    c0 = cyc;
    if (with_exit) occ_new = occ_exp;
    else if (occ_exp < CAP) occ_new = occ_exp + 1;
    else occ_new = occ_exp;
    push(c0 + 1,  mk(1'b1, 1'b0, 1'b0, 1'b0, occ_exp));
    push(c0 + 17, mk(1'b0, 1'b0, 1'b1, 1'b0, occ_exp));
    push(c0 + 34, mk(1'b0, 1'b1, 1'b0, 1'b0, occ_new));
    push(c0 + 50, mk(1'b0, 1'b0, 1'b0, 1'b0, occ_new));
    access_ok = 1'b1;
    @(negedge clk);
    access_ok = 1'b0;
    repeat (16) @(negedge clk);
    ent_sensor = 1'b1;
    repeat (10) @(negedge clk);
    ent_sensor = 1'b0;
    if (with_exit) exit_sensor = 1'b1;
    repeat (10) @(negedge clk);
    exit_sensor = 1'b0;
    occ_exp = occ_new;
    wait_drain(name, 60);
  endtask

  task automatic car_exit(input string name);
    int c0;
    c0 = cyc;
    if (occ_exp > 0) begin
      occ_exp = occ_exp - 1;
      push(c0 + 7, mk(1'b0, 1'b0, 1'b0, 1'b0, occ_exp));
    end
    exit_sensor = 1'b1;
    repeat (10) @(negedge clk);
    exit_sensor = 1'b0;
    repeat (10) @(negedge clk);
    wait_drain(name, 20);
  endtask

  initial begin
    int c0;
    int l0;
    reset_n     = 1'b0;
    access_ok   = 1'b0;
    ent_sensor  = 1'b0;
    exit_sensor = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", cur_v(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_release_outputs", cur_v(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Normal entry: 16-cycle raise, occupancy 0 -> 1, 16-cycle lower
    car_entry("normal_entry", 1'b0);

    // Bounce while open: no count, hold timeout 64 cycles after opening
    c0 = cyc;
    push(c0 + 1,  mk(1'b1, 1'b0, 1'b0, 1'b0, 1));
    push(c0 + 17, mk(1'b0, 1'b0, 1'b1, 1'b0, 1));
    push(c0 + 81, mk(1'b0, 1'b1, 1'b0, 1'b1, 1));
    push(c0 + 82, mk(1'b0, 1'b1, 1'b0, 1'b0, 1));
    push(c0 + 97, mk(1'b0, 1'b0, 1'b0, 1'b0, 1));
    access_ok = 1'b1;
    @(negedge clk);
    access_ok = 1'b0;
    repeat (18) @(negedge clk);
    ent_sensor = 1'b1;
    @(negedge clk);
    ent_sensor = 1'b0;
    @(negedge clk);
    ent_sensor = 1'b1;
    @(negedge clk);
    ent_sensor = 1'b0;
    wait_drain("bounce", 120);

    // Second car (lot now full) with a safety reversal 5 cycles into lowering
    c0 = cyc;
    l0 = c0 + 34;
    push(c0 + 1,  mk(1'b1, 1'b0, 1'b0, 1'b0, 1));
    push(c0 + 17, mk(1'b0, 1'b0, 1'b1, 1'b0, 1));
    push(l0,      mk(1'b0, 1'b1, 1'b0, 1'b0, 2));
    push(l0 + 12, mk(1'b1, 1'b0, 1'b0, 1'b0, 2));
    push(l0 + 28, mk(1'b0, 1'b0, 1'b1, 1'b0, 2));
    push(l0 + 92, mk(1'b0, 1'b1, 1'b0, 1'b1, 2));
    push(l0 + 93, mk(1'b0, 1'b1, 1'b0, 1'b0, 2));
    push(l0 + 108, mk(1'b0, 1'b0, 1'b0, 1'b0, 2));
    access_ok = 1'b1;
    @(negedge clk);
    access_ok = 1'b0;
    repeat (16) @(negedge clk);
    ent_sensor = 1'b1;
    repeat (10) @(negedge clk);
    ent_sensor = 1'b0;
    repeat (12) @(negedge clk);
    ent_sensor = 1'b1;
    repeat (8) @(negedge clk);
    ent_sensor = 1'b0;
    occ_exp = 2;
    wait_drain("safety_reverse", 130);

    // Full lot: access is ignored, then one exit frees a slot
    access_ok = 1'b1;
    repeat (5) @(negedge clk);
    access_ok = 1'b0;
    repeat (20) @(negedge clk);
    chk("full_lot_stays_closed", cur_v(), mk(1'b0, 1'b0, 1'b0, 1'b0, 2));
    car_exit("exit_from_full");
    chk("after_exit", cur_v(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1));

    // Car passes in the same cycle as an exit rise: occupancy unchanged
    car_entry("simultaneous", 1'b1);
    car_exit("exit_to_empty");
    car_exit("exit_when_empty");
    chk("empty_saturates", cur_v(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));

    // Reset in the middle of a raise
    car_entry("pre_reset_entry", 1'b0);
    c0 = cyc;
    push(c0 + 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1));
    push(c0 + 8, mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    access_ok = 1'b1;
    @(negedge clk);
    access_ok = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    occ_exp = 0;
    wait_drain("reset_mid_raise", 20);
    chk("after_reset_closed", cur_v(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
